// File: rtl/beat_sequencer.sv
// Beat sequencer: generates SCAN1/ACTION1/SCAN2/ACTION2 beats, digit strobes, run/step/halt control.
// Latency: start condition at edge n gives beat 0 / digit 0 in the cycle after edge n; all outputs registered.
// Backpressure: none; step while busy is dropped and stop_req counts only during ACTION2 digit periods.
module beat_sequencer #(
  parameter int WORD_BITS    = 20,
  parameter int FLYBACK_TIME = 2,
  parameter int CW           = $clog2(WORD_BITS + FLYBACK_TIME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          stop_req,
  output logic [1:0]    beat,
  output logic [CW-1:0] digit,
  output logic          digit_valid,
  output logic          flyback,
  output logic          word_start,
  output logic          kcc,
  output logic          action_wf,
  output logic          xtb,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN1, S_ACTION1, S_SCAN2, S_ACTION2
  } state_t;

  localparam logic [CW-1:0] C_LAST_DIGIT = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] C_TERM       = CW'(WORD_BITS + FLYBACK_TIME - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_stop;
  logic          r_run_q;
  logic          r_step_only;
  logic          r_halted;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_stop_nxt;
  logic          w_step_only_nxt;
  logic          w_halted_nxt;
  logic          w_run_start;
  logic          w_term;
  logic          w_busy_nxt;
  logic          w_dv_nxt;
  logic [1:0]    w_beat_nxt;

  assign w_run_start = run && (!r_run_q || !r_halted);
  assign w_term      = (r_cnt == C_TERM);

  // Next-state: start from IDLE, beat counter, beat advance and end-of-instruction decision
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_stop_nxt      = r_stop;
    w_step_only_nxt = r_step_only;
    w_halted_nxt    = r_halted;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      if (w_run_start || step) begin
        w_state_nxt     = S_SCAN1;
        w_halted_nxt    = 1'b0;
        w_stop_nxt      = 1'b0;
        // A step that coincides with a run start still runs continuously
        w_step_only_nxt = !w_run_start;
      end
    end else begin
      w_cnt_nxt = w_term ? '0 : r_cnt + 1'b1;
      if (r_state == S_ACTION2 && r_cnt <= C_LAST_DIGIT) begin
        w_stop_nxt = r_stop || stop_req;
      end
      if (w_term) begin
        case (r_state)
          S_SCAN1:   w_state_nxt = S_ACTION1;
          S_ACTION1: w_state_nxt = S_SCAN2;
          S_SCAN2:   w_state_nxt = S_ACTION2;
          default: begin
            if (r_stop) begin
              w_state_nxt  = S_IDLE;
              w_halted_nxt = 1'b1;
              w_stop_nxt   = 1'b0;
            end else if (run && !r_step_only) begin
              w_state_nxt = S_SCAN1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Output decode of the upcoming state so the strobes can be registered with it
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_dv_nxt   = w_busy_nxt && (w_cnt_nxt <= C_LAST_DIGIT);
    case (w_state_nxt)
      S_ACTION1: w_beat_nxt = 2'd1;
      S_SCAN2:   w_beat_nxt = 2'd2;
      S_ACTION2: w_beat_nxt = 2'd3;
      default:   w_beat_nxt = 2'd0;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stop      <= 1'b0;
      r_run_q     <= 1'b0;
      r_step_only <= 1'b0;
      r_halted    <= 1'b0;
      beat        <= 2'd0;
      digit       <= '0;
      digit_valid <= 1'b0;
      flyback     <= 1'b0;
      word_start  <= 1'b0;
      kcc         <= 1'b0;
      action_wf   <= 1'b0;
      xtb         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stop      <= w_stop_nxt;
      r_run_q     <= run;
      r_step_only <= w_step_only_nxt;
      r_halted    <= w_halted_nxt;
      beat        <= w_beat_nxt;
      // Digit freezes at the last index through flyback, and reads 0 when idle
      digit       <= !w_busy_nxt ? '0 : (w_dv_nxt ? w_cnt_nxt : C_LAST_DIGIT);
      digit_valid <= w_dv_nxt;
      flyback     <= w_busy_nxt && !w_dv_nxt;
      word_start  <= w_busy_nxt && (w_cnt_nxt == '0);
      kcc         <= (w_state_nxt == S_ACTION2) && (w_cnt_nxt == '0);
      action_wf   <= w_dv_nxt && (w_state_nxt == S_ACTION1 || w_state_nxt == S_ACTION2);
      xtb         <= w_dv_nxt && (w_state_nxt == S_ACTION2);
      busy        <= w_busy_nxt;
    end
  end

  assign halted = r_halted;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer with WORD_BITS=4, FLYBACK_TIME=2 (6-clock beats, 24-clock instructions).
// Latency: reference model advances on each rising edge and is compared 1 time unit later.
// Backpressure: none; directed scenarios followed by a randomized run/step/stop/reset phase.
module tb_beat_sequencer;
  localparam int WB = 4;
  localparam int FB = 2;
  localparam int BL = WB + FB;
  localparam int IL = 4 * BL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       stop_req = 1'b0;
  logic [1:0] beat;
  logic [2:0] digit;
  logic       digit_valid, flyback, word_start, kcc, action_wf, xtb, busy, halted;

  int total = 0;
  int bad = 0;
  int n_busy, n_xtb, n_kcc, n_awf;

  // Reference model state: position within the 24-clock instruction
  bit m_busy, m_halted, m_run_q, m_stop, m_step_only;
  int m_pos;

  beat_sequencer #(.WORD_BITS(WB), .FLYBACK_TIME(FB)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .stop_req(stop_req),
    .beat(beat), .digit(digit), .digit_valid(digit_valid), .flyback(flyback),
    .word_start(word_start), .kcc(kcc), .action_wf(action_wf), .xtb(xtb),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit run_start;
    if (rst) begin
      m_busy = 0; m_halted = 0; m_run_q = 0; m_stop = 0; m_step_only = 0; m_pos = 0;
    end else begin
      run_start = run && (!m_run_q || !m_halted);
      if (!m_busy) begin
        if (run_start || step) begin
          m_busy = 1; m_pos = 0; m_halted = 0; m_stop = 0;
          m_step_only = !run_start;
        end
      end else begin
        if (m_pos / BL == 3 && m_pos % BL < WB && stop_req) m_stop = 1;
        if (m_pos == IL - 1) begin
          if (m_stop) begin
            m_busy = 0; m_halted = 1; m_stop = 0;
          end else if (run && !m_step_only) begin
            m_pos = 0;
          end else begin
            m_busy = 0;
          end
        end else begin
          m_pos++;
        end
      end
      m_run_q = run;
    end
  endtask

  function automatic logic [31:0] model_out();
    int b, o;
    logic [1:0] e_beat;
    logic [2:0] e_digit;
    logic dv, fb, ws, kc, aw, xt;
    b = m_pos / BL;
    o = m_pos % BL;
    e_beat  = 2'(b);
    e_digit = 3'((o < WB) ? o : WB - 1);
    dv = (o < WB);
    fb = !dv;
    ws = (o == 0);
    kc = (b == 3) && (o == 0);
    aw = (b == 1 || b == 3) && dv;
    xt = (b == 3) && dv;
    if (!m_busy) return {31'b0, m_halted};
    return {19'b0, e_beat, e_digit, dv, fb, ws, kc, aw, xt, 1'b1, m_halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outs", {19'b0, beat, digit, digit_valid, flyback, word_start, kcc, action_wf, xtb, busy, halted},
          model_out());
    n_busy += int'(busy);
    n_xtb  += int'(xtb);
    n_kcc  += int'(kcc);
    n_awf  += int'(action_wf);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_busy = 0; n_xtb = 0; n_kcc = 0; n_awf = 0;
  endtask

  // Advance until the DUT shows the given beat/digit while busy, bounded
  task automatic wait_pos(input logic [1:0] b, input logic [2:0] d);
    int n;
    n = 0;
    while (!(busy && beat == b && digit == d && digit_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    clr();
    // Reset held with run high: all outputs stay 0
    rst = 1'b1; run = 1'b1;
    ticks(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_start", {30'b0, beat}, 32'd0);
    check("rel_ws", 32'(word_start), 32'd1);
    run = 1'b0;
    ticks(IL);

    // Single step
    clr();
    pulse_step();
    ticks(IL + 6);
    check("step_busy", n_busy, IL);
    check("step_xtb", n_xtb, WB);
    check("step_kcc", n_kcc, 1);
    check("step_awf", n_awf, 2 * WB);
    check("step_halt", 32'(halted), 32'd0);

    // Continuous run, drop run mid-ACTION1 of the third instruction
    clr();
    run = 1'b1;
    ticks(2 * IL + BL + 2);
    run = 1'b0;
    ticks(IL + 10);
    check("run_busy", n_busy, 3 * IL);

    // Stop on ACTION2 digit 2, then no restart while run stays high
    run = 1'b1;
    wait_pos(2'd3, 3'd2);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    ticks(BL);
    check("stop_halt", 32'(halted), 32'd1);
    check("stop_idle", 32'(busy), 32'd0);
    clr();
    ticks(30);
    check("stop_norestart", n_busy, 0);
    run = 1'b0;
    tick();
    run = 1'b1;
    ticks(2);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_halt", 32'(halted), 32'd0);

    // stop_req in SCAN2 and in ACTION2 flyback only: no halt
    wait_pos(2'd2, 3'd1);
    stop_req = 1'b1; ticks(2); stop_req = 1'b0;
    run = 1'b0;
    wait_pos(2'd3, 3'd3);
    tick();
    stop_req = 1'b1; ticks(2); stop_req = 1'b0;
    ticks(BL);
    check("ign_stop_halt", 32'(halted), 32'd0);

    // Step pulses while busy are dropped
    clr();
    pulse_step();
    ticks(5); pulse_step(); ticks(7); pulse_step();
    ticks(IL);
    check("ign_step_busy", n_busy, IL);

    // Mid-operation reset at ACTION1 digit 1
    pulse_step();
    wait_pos(2'd1, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    tick();
    clr();
    pulse_step();
    ticks(IL + 4);
    check("mrst_step_busy", n_busy, IL);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) run = ~run;
      step     = ($urandom_range(0, 30) == 0);
      stop_req = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 400) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Master timing controller for the reduced machine's serial datapath. It generates the beat structure of every instruction: SCAN1, ACTION1, SCAN2, ACTION2. Each beat is one word of digit periods followed by a flyback blanking interval. It also supplies the per-digit strobes that sequence the accumulator and store: action waveform, carry clear and store write window. It implements run, single-step and halt-on-stop control.

## Interface

- `WORD_BITS`, default 20: digit periods per beat (word length); must be ≥2.
- `FLYBACK_TIME`, default 2: blanking clocks after each word; must be ≥1.
- `CW`, default $clog2(WORD_BITS+FLYBACK_TIME): beat counter width; derived, do not override.

- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level; continuous execution request.
- `step` input 1: one-clock pulse; execute exactly one instruction.
- `stop_req` input 1: level from instruction decode; stop instruction present.
- `beat` output 2: current beat (0 = SCAN1, 1 = ACTION1, 2 = SCAN2, 3 = ACTION2); valid when `busy`.
- `digit` output CW: digit index within the word, 0..WORD_BITS-1; holds WORD_BITS-1 during flyback.
- `digit_valid` output 1: high during digit periods of any beat.
- `flyback` output 1: high during the FLYBACK_TIME blanking clocks of any beat.
- `word_start` output 1: high for the digit-0 clock of every beat.
- `kcc` output 1: carry-clear; high for the digit-0 clock of ACTION2 only.
- `action_wf` output 1: high during digit periods of ACTION1 and ACTION2.
- `xtb` output 1: store write window; high during digit periods of ACTION2 only.
- `busy` output 1: an instruction is in progress.
- `halted` output 1: machine stopped by `stop_req`.

## Operation

- States: IDLE, SCAN1, ACTION1, SCAN2, ACTION2.
- Reset behaviour:
  - state = IDLE; beat counter = 0; stop latch = 0; run-edge register = 0.
  - All outputs are 0, including `halted`, `busy` and `digit`.
- Beat counter:
  - Runs 0..WORD_BITS+FLYBACK_TIME-1 in every non-IDLE state.
  - Counter < WORD_BITS: `digit_valid` = 1 and `digit` = counter.
  - Otherwise: `flyback` = 1.
  - On the terminal count it returns to 0 and the state advances: SCAN1 → ACTION1 → SCAN2 → ACTION2.
- Start condition, evaluated only in IDLE: a rising edge of `run` (registered compare), or `run` = 1 with `halted` = 0, or a `step` pulse.
  - On start, go to SCAN1 with counter 0 and clear `halted`.
  - Simultaneous `run` and `step` gives a single start; continuous mode is in effect while `run` = 1.
- `stop_req` is sampled on every ACTION2 digit-period clock and ORed into the stop latch. It is ignored in all other states.
- End of ACTION2 (terminal count):
  - Stop latch = 1: go to IDLE, set `halted` = 1, clear the latch.
  - Else, `run` = 1 and the instruction was not started by `step` alone: go to SCAN1. Back-to-back instructions have no gap.
  - Else: go to IDLE.
- `step` while `busy` is ignored; it is not queued.
- Dropping `run` mid-instruction completes the current instruction, then goes to IDLE.
- Leaving `halted`: after a halt, `run` held high does not restart. A new `run` rising edge or a `step` is required.
- `rst` asserted mid-beat forces IDLE on the next edge regardless of state.

## Timing

- Beat length: WORD_BITS+FLYBACK_TIME clocks. Instruction length: 4× that.
- Start latency: start condition at edge n puts `beat` = 0 and `digit` = 0, with `word_start` = 1, in the cycle after edge n.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- `busy` is high from the first SCAN1 clock through the last ACTION2 flyback clock.
- `halted` rises in the same cycle that `busy` falls.
- `stop_req` is sampled up to and including the last ACTION2 digit clock. A `stop_req` asserted only during ACTION2 flyback does not halt.

## Test plan

- **Reset:** WORD_BITS=4, FLYBACK_TIME=2; hold `rst` 3 clocks with `run` = 1 → all outputs 0, state IDLE throughout. Release → SCAN1 digit 0 on the next cycle.
- **Single step:** one `step` pulse from IDLE → exactly 24 busy clocks.
  - `beat` sequence is 0,1,2,3, each lasting 6 clocks (digits 0–3, then 2 flyback).
  - `xtb` high for 4 clocks, `kcc` high for 1 clock, `action_wf` high for 8 clocks.
  - Then IDLE with `halted` = 0.
- **Continuous run:** `run` held high for 3 instructions → 72 consecutive busy clocks, SCAN1 directly following ACTION2 flyback. Drop `run` mid-ACTION1 of instruction 3 → IDLE after that instruction's ACTION2.
- **Stop:** with `run` = 1, pulse `stop_req` on ACTION2 digit 2 → `halted` = 1 and `busy` = 0 after that beat, and no restart while `run` stays high. A `run` low→high transition restarts and clears `halted`.
- **Ignored inputs:** `stop_req` during SCAN2 only, then during ACTION2 flyback only → no halt. `step` pulses during a busy instruction → no extra instruction.
- **Mid-operation reset:** assert `rst` at ACTION1 digit 1 → next cycle all outputs 0 and IDLE. A subsequent `step` gives a clean 24-clock instruction.
